banyan_tagger: RTL and testbench
================================

# banyan_tagger

Front-end for the 8-port compaction banyan. Takes beats of up to N sparse payload words and gives each valid word a 3-bit destination tag. Destinations are the running prefix-sum of valid lanes plus a rotating base pointer, so successive beats pack contiguously and wrap modulo N. Outputs feed the banyan inputs directly: data and routing tag in one word, plus a per-lane valid.

## Interface
- PW, 32, payload width per lane
- DW, PW+3, output word width: payload plus 3-bit routing tag
- N, 8, lane count (fixed at 8; tag width is 3)
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- i_data  input  PW x N (unpacked [N-1:0])  payload per lane
- i_valid  input  N  per-lane valid, any pattern
- i_beat  input  1  beat strobe; lanes are sampled only when high
- i_last  input  1  last beat of a frame; qualified by i_beat
- o_data  output  DW x N  {tag[2:0], payload}; tag in [DW-1:DW-3], where DW-1 is the destination MSB and DW-3 the LSB
- o_valid  output  N  per-lane valid
- o_wrap  output  1  this beat's words cross or reach destination N-1 (base + count ≥ N)
- o_last  output  1  delayed i_last
- o_word_cnt  output  16  words tagged so far in the current frame, including this beat

## Operation
- Stage A, registered on i_beat:
  - Capture i_data, i_valid and i_last.
  - Compute an exclusive prefix popcount pre[k] of i_valid[k-1:0] (4 bits), and the beat total cnt (0..8).
- Stage B, registered every cycle from stage A:
  - tag[k] = (base + pre[k]) mod 8.
  - o_valid[k] = stage-A valid[k].
  - o_wrap = (base + cnt ≥ 8).
  - o_word_cnt = frame_cnt + cnt (mod 2^16).
- base (3 bits) and frame_cnt (16 bits) update when stage B consumes a stage-A beat:
  - base <= (base + cnt) mod 8; frame_cnt <= frame_cnt + cnt.
  - If that beat carries last: base <= 0 and frame_cnt <= 0 after the beat is emitted.
- Invalid lanes: o_valid low, tag = (base + pre[k]) mod 8, payload passes through unchanged. Downstream ignores them.
- Tags of valid lanes within a beat are distinct and cyclically consecutive. No banyan collision is possible.
- Cycles with i_beat low: stage A valid is cleared, and stage B emits o_valid = 0, o_wrap = 0, o_last = 0. o_word_cnt holds its last value. base and frame_cnt are unchanged.
- An all-zero i_valid with i_beat high is a legal beat: cnt = 0, base is unchanged, o_wrap = 0. With i_last it still resets base and frame_cnt (empty frame end).
- i_beat and i_last asserted on back-to-back cycles: the next frame's first beat uses base 0.

## Timing
- Latency 2 cycles from i_beat sampled to o_* (3 with the macro below). Full throughput: one beat per cycle with no bubbles.
- No backpressure. The banyan and the downstream assembler accept every cycle.
- Reset, asynchronous:
  - o_data = 0, o_valid = 0, o_wrap = 0, o_last = 0, o_word_cnt = 0.
  - base = 0, frame_cnt = 0, and all pipeline valids = 0.
  - Reset mid-frame discards in-flight beats. The first post-reset beat starts at base 0.
- o_word_cnt wraps 0xFFFF -> 0x0000 silently.

## Configuration
- BANYAN_TAGGER_OUTREG_EN defined:
  - An extra register stage is placed on all outputs, for timing closure into the banyan.
  - Latency 3; reset values unchanged.
  - The base and frame_cnt update rule is unchanged.
- Undefined: latency 2, with outputs driven straight from the stage-B registers.

## Test plan
- Reset, then beat i_valid=8'b1111_1111 with payload k in lane k -> 2 cycles later:
  - tags 0..7 in lane order, o_valid=0xFF, o_wrap=1, o_word_cnt=8.
  - base returns to 0.
- Beat i_valid=8'b1010_0101, then 8'b0000_1111 ->
  - Beat 1: lanes 0,2,5,7 get tags 0,1,2,3; o_wrap=0; o_word_cnt=4.
  - Beat 2: lanes 0..3 get tags 4,5,6,7; o_wrap=1; o_word_cnt=8.
- Wrap-around: base=6 (after 6 words), then i_valid=0x0F ->
  - tags 6,7,0,1, o_wrap=1, base becomes 2.
- i_last on a beat with 3 valid words (base=5) ->
  - tags 5,6,7, o_last=1, o_word_cnt = previous count + 3.
  - Next beat i_valid=0x01 -> tag 0, o_word_cnt=1.
- Idle and empty beats:
  - i_beat=0 for 5 cycles -> o_valid=0, base unchanged.
  - i_beat=1 with i_valid=0 -> o_valid=0, o_wrap=0, counters unchanged.
- Assert rst_n low mid-frame with 2 beats in flight -> outputs go to 0 immediately. After release, a beat with i_valid=0x80 gets tag 0 on lane 7, and o_word_cnt=1.

Source files
------------

// File: rtl/banyan_tagger.sv
// Destination tagger for the 8-port compaction banyan: packs valid lanes contiguously from a rotating base.
// Define BANYAN_TAGGER_OUTREG_EN to add a retiming register on all outputs (latency 2 -> 3).
module banyan_tagger #(
  parameter int PW = 32,
  parameter int N  = 8,
  parameter int DW = PW + 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] i_data [N-1:0],
  input  logic [N-1:0]  i_valid,
  input  logic          i_beat,
  input  logic          i_last,
  output logic [DW-1:0] o_data [N-1:0],
  output logic [N-1:0]  o_valid,
  output logic          o_wrap,
  output logic          o_last,
  output logic [15:0]   o_word_cnt
);

  logic [PW-1:0] a_data_q [N-1:0];
  logic [PW-1:0] a_data_d [N-1:0];
  logic [2:0]    a_pre_q  [N-1:0];
  logic [2:0]    a_pre_d  [N-1:0];
  logic [N-1:0]  a_valid_q, a_valid_d;
  logic [3:0]    a_cnt_q, a_cnt_d;
  logic          a_beat_q, a_beat_d;
  logic          a_last_q, a_last_d;
  logic [3:0]    acc;

  logic [DW-1:0] b_data_q [N-1:0];
  logic [DW-1:0] b_data_d [N-1:0];
  logic [N-1:0]  b_valid_q, b_valid_d;
  logic          b_wrap_q, b_wrap_d;
  logic          b_last_q, b_last_d;
  logic [15:0]   b_wcnt_q, b_wcnt_d;
  logic [2:0]    base_q, base_d;
  logic [15:0]  frame_cnt_q, frame_cnt_d;
  logic [3:0]    base_sum;
  logic [2:0]    tag;

  // Stage A: exclusive prefix popcount; pre never exceeds 7 so 3 bits hold it.
  always_comb begin
    a_beat_d  = i_beat;
    a_valid_d = i_beat ? i_valid : '0;
    a_last_d  = i_beat & i_last;
    a_data_d  = a_data_q;
    acc       = '0;
    for (int k = 0; k < N; k++) begin
      a_pre_d[k] = acc[2:0];
      if (i_beat) begin
        a_data_d[k] = i_data[k];
        acc         = acc + {3'b000, i_valid[k]};
      end
    end
    a_cnt_d = acc;
  end

  // Stage B: tags relative to the running base; bookkeeping advances only on a consumed beat.
  always_comb begin
    b_data_d    = b_data_q;
    b_valid_d   = '0;
    b_wrap_d    = 1'b0;
    b_last_d    = 1'b0;
    b_wcnt_d    = b_wcnt_q;
    base_d      = base_q;
    frame_cnt_d = frame_cnt_q;
    base_sum    = {1'b0, base_q} + a_cnt_q;
    tag         = '0;
    if (a_beat_q) begin
      for (int k = 0; k < N; k++) begin
        tag         = base_q + a_pre_q[k];
        b_data_d[k] = {tag, a_data_q[k]};
      end
      b_valid_d = a_valid_q;
      b_wrap_d  = base_sum[3];
      b_last_d  = a_last_q;
      b_wcnt_d  = frame_cnt_q + {12'h000, a_cnt_q};
      if (a_last_q) begin
        base_d      = '0;
        frame_cnt_d = '0;
      end else begin
        base_d      = base_sum[2:0];
        frame_cnt_d = b_wcnt_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        a_data_q[k] <= '0;
        a_pre_q[k]  <= '0;
        b_data_q[k] <= '0;
      end
      a_valid_q   <= '0;
      a_cnt_q     <= '0;
      a_beat_q    <= 1'b0;
      a_last_q    <= 1'b0;
      b_valid_q   <= '0;
      b_wrap_q    <= 1'b0;
      b_last_q    <= 1'b0;
      b_wcnt_q    <= '0;
      base_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      a_data_q    <= a_data_d;
      a_pre_q     <= a_pre_d;
      a_valid_q   <= a_valid_d;
      a_cnt_q     <= a_cnt_d;
      a_beat_q    <= a_beat_d;
      a_last_q    <= a_last_d;
      b_data_q    <= b_data_d;
      b_valid_q   <= b_valid_d;
      b_wrap_q    <= b_wrap_d;
      b_last_q    <= b_last_d;
      b_wcnt_q    <= b_wcnt_d;
      base_q      <= base_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef BANYAN_TAGGER_OUTREG_EN
  logic [DW-1:0] o_data_q [N-1:0];
  logic [N-1:0]  o_valid_q;
  logic          o_wrap_q, o_last_q;
  logic [15:0]   o_wcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) o_data_q[k] <= '0;
      o_valid_q <= '0;
      o_wrap_q  <= 1'b0;
      o_last_q  <= 1'b0;
      o_wcnt_q  <= '0;
    end else begin
      o_data_q  <= b_data_q;
      o_valid_q <= b_valid_q;
      o_wrap_q  <= b_wrap_q;
      o_last_q  <= b_last_q;
      o_wcnt_q  <= b_wcnt_q;
    end
  end

  assign o_data     = o_data_q;
  assign o_valid    = o_valid_q;
  assign o_wrap     = o_wrap_q;
  assign o_last     = o_last_q;
  assign o_word_cnt = o_wcnt_q;
`else
  assign o_data     = b_data_q;
  assign o_valid    = b_valid_q;
  assign o_wrap     = b_wrap_q;
  assign o_last     = b_last_q;
  assign o_word_cnt = b_wcnt_q;
`endif

endmodule

// File: tb/tb_banyan_tagger.sv
// Directed bench for banyan_tagger: hand-computed tags, wrap, frame counts, idle/empty beats and reset.
module tb_banyan_tagger;

`ifdef BANYAN_TAGGER_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] i_data [7:0];
  logic [7:0]  i_valid;
  logic        i_beat;
  logic        i_last;
  logic [34:0] o_data [7:0];
  logic [7:0]  o_valid;
  logic        o_wrap;
  logic        o_last;
  logic [15:0] o_word_cnt;

  int n_chk = 0;
  int n_err = 0;

  banyan_tagger dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .i_beat    (i_beat),
    .i_last    (i_last),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_wrap    (o_wrap),
    .o_last    (o_last),
    .o_word_cnt(o_word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic [7:0] v, input logic l, input logic [31:0] pb);
    i_beat  = b;
    i_valid = v;
    i_last  = l;
    for (int k = 0; k < 8; k++) i_data[k] = pb + 32'(k);
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 32'h0);
  endtask

  task automatic send1(input logic [7:0] v, input logic l, input logic [31:0] pb);
    drive(1'b1, v, l, pb);
    step();
    idle();
    repeat (LAT - 1) step();
  endtask

  // etags packs the expected tag of lane k in bits [3k+2:3k].
  task automatic chk_beat(input string name, input logic [7:0] ev, input logic [23:0] etags,
                          input logic ew, input logic el, input logic [15:0] ewc,
                          input logic [31:0] pb);
    chk({name, " valid"}, 64'(o_valid), 64'(ev));
    chk({name, " wrap"}, 64'(o_wrap), 64'(ew));
    chk({name, " last"}, 64'(o_last), 64'(el));
    chk({name, " word_cnt"}, 64'(o_word_cnt), 64'(ewc));
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s tag%0d", name, k), 64'(o_data[k][34:32]), 64'(etags[3*k +: 3]));
      chk($sformatf("%s pay%0d", name, k), 64'(o_data[k][31:0]), 64'(pb + 32'(k)));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    step();
    step();
    chk("rst valid", 64'(o_valid), 64'h0);
    chk("rst wrap", 64'(o_wrap), 64'h0);
    chk("rst last", 64'(o_last), 64'h0);
    chk("rst word_cnt", 64'(o_word_cnt), 64'h0);
    chk("rst data0", 64'(o_data[0]), 64'h0);
    chk("rst data7", 64'(o_data[7]), 64'h0);
    rst_n = 1'b1;
    step();

    // full beat from base 0: tags 0..7, base wraps back to 0
    send1(8'hFF, 1'b0, 32'h0);
    chk_beat("full", 8'hFF, 24'hFAC688, 1'b1, 1'b0, 16'd8, 32'h0);

    // empty beat closing the frame
    send1(8'h00, 1'b1, 32'h100);
    chk_beat("empty_last", 8'h00, 24'h000000, 1'b0, 1'b1, 16'd8, 32'h100);

    // two sparse beats back to back
    drive(1'b1, 8'hA5, 1'b0, 32'h200);
    step();
    drive(1'b1, 8'h0F, 1'b0, 32'h300);
    step();
    idle();
    repeat (LAT - 2) step();
    chk_beat("sparse1", 8'hA5, 24'h6D2448, 1'b0, 1'b0, 16'd4, 32'h200);
    step();
    chk_beat("sparse2", 8'h0F, 24'h000FAC, 1'b1, 1'b0, 16'd8, 32'h300);

    // reach base 6, then wrap through 7 -> 0 -> 1
    send1(8'h3F, 1'b0, 32'h400);
    chk_beat("to_base6", 8'h3F, 24'hDAC688, 1'b0, 1'b0, 16'd14, 32'h400);
    send1(8'h0F, 1'b0, 32'h500);
    chk_beat("wrap", 8'h0F, 24'h49223E, 1'b1, 1'b0, 16'd18, 32'h500);

    // base 2 -> 5, then last beat with 3 words, immediately followed by next frame
    send1(8'h07, 1'b0, 32'h600);
    chk_beat("to_base5", 8'h07, 24'hB6DB1A, 1'b0, 1'b0, 16'd21, 32'h600);
    drive(1'b1, 8'h46, 1'b1, 32'h700);
    step();
    drive(1'b1, 8'h01, 1'b0, 32'h800);
    step();
    idle();
    repeat (LAT - 2) step();
    chk_beat("last3", 8'h46, 24'h1FFFAD, 1'b1, 1'b1, 16'd24, 32'h700);
    step();
    chk_beat("new_frame", 8'h01, 24'h249248, 1'b0, 1'b0, 16'd1, 32'h800);

    // idle cycles: nothing emitted, count held
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("idle%0d valid", c), 64'(o_valid), 64'h0);
      chk($sformatf("idle%0d wrap", c), 64'(o_wrap), 64'h0);
      chk($sformatf("idle%0d last", c), 64'(o_last), 64'h0);
      chk($sformatf("idle%0d word_cnt", c), 64'(o_word_cnt), 64'd1);
    end

    // empty beat mid-frame, then confirm base is still 1
    send1(8'h00, 1'b0, 32'h900);
    chk_beat("empty", 8'h00, 24'h249249, 1'b0, 1'b0, 16'd1, 32'h900);
    send1(8'h01, 1'b0, 32'hA00);
    chk_beat("after_empty", 8'h01, 24'h492491, 1'b0, 1'b0, 16'd2, 32'hA00);

    // reset with beats in flight
    drive(1'b1, 8'hFF, 1'b0, 32'hB00);
    step();
    drive(1'b1, 8'hFF, 1'b0, 32'hC00);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst valid", 64'(o_valid), 64'h0);
    chk("midrst wrap", 64'(o_wrap), 64'h0);
    chk("midrst word_cnt", 64'(o_word_cnt), 64'h0);
    chk("midrst data3", 64'(o_data[3]), 64'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    send1(8'h80, 1'b0, 32'hD00);
    chk_beat("post_rst", 8'h80, 24'h000000, 1'b0, 1'b0, 16'd1, 32'hD00);

    // close frame (base 1), then stream 65536 words for the counter rollover
    send1(8'h00, 1'b1, 32'hE00);
    chk_beat("close", 8'h00, 24'h249249, 1'b0, 1'b1, 16'd1, 32'hE00);
    for (int b = 0; b < 8192; b++) begin
      drive(1'b1, 8'hFF, 1'b0, 32'hF00);
      step();
    end
    idle();
    repeat (LAT - 1) step();
    chk_beat("rollover", 8'hFF, 24'hFAC688, 1'b1, 1'b0, 16'h0000, 32'hF00);
    send1(8'h01, 1'b0, 32'h1000);
    chk_beat("after_roll", 8'h01, 24'h249248, 1'b0, 1'b0, 16'd1, 32'h1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
